// File: rtl/ex_div_seq_pkg.sv
// Shared execute-stage types and constants for the iterative divider.
package core_pkg;
    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction
endpackage

// File: rtl/ex_div_seq_if.sv
// Operand/result bundle between the EX stage and the divide sequencer.
interface ex_div_seq_if import core_pkg::*; ();
    logic            start_i;
    div_op_t         div_op_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic            flush_i;
    logic            stall_o;
    logic            valid_o;
    logic [XLEN-1:0] res_o;

    modport master (
        output start_i, div_op_i, op1_i, op2_i, flush_i,
        input  stall_o, valid_o, res_o
    );

    modport slave (
        input  start_i, div_op_i, op1_i, op2_i, flush_i,
        output stall_o, valid_o, res_o
    );
endinterface

// File: rtl/ex_div_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step import core_pkg::*; (
    input  logic [XLEN:0]   i_r,
    input  logic [XLEN-1:0] i_q,
    input  logic [XLEN-1:0] i_d,
    output logic [XLEN:0]   o_r,
    output logic [XLEN-1:0] o_q
);
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_fits;

    assign w_shift = {i_r[XLEN-1:0], i_q[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_d};
    // A set top bit means the true shifted value exceeds 2^32, so it always fits.
    assign w_fits  = i_r[XLEN] | ~w_diff[XLEN];

    assign o_r = w_fits ? w_diff : w_shift;
    assign o_q = {i_q[XLEN-2:0], w_fits};
endmodule

// File: rtl/ex_div_seq.sv
// DIV/DIVU/REM/REMU sequencer: 32-step restoring divide that stalls the pipeline while busy.
module ex_div_seq import core_pkg::*; (
    input  logic       clk,
    input  logic       reset_n,
    ex_div_seq_if.slave bus
);
    div_state_t      r_state;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_quo;
    logic [XLEN:0]   r_rem;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_res;
    logic            r_valid;

    logic            w_signed;
    logic            w_is_div;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_dz;
    logic            w_ovf;
    logic [XLEN-1:0] w_special;
    logic [XLEN:0]   w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_quo_fin;
    logic [XLEN-1:0] w_rem_fin;
    logic [XLEN-1:0] w_calc_res;

    assign w_signed = ~bus.div_op_i[0];
    assign w_is_div = ~bus.div_op_i[1];
    assign w_a_neg  = w_signed & bus.op1_i[XLEN-1];
    assign w_b_neg  = w_signed & bus.op2_i[XLEN-1];
    assign w_abs1   = w_a_neg ? neg2c(bus.op1_i) : bus.op1_i;
    assign w_abs2   = w_b_neg ? neg2c(bus.op2_i) : bus.op2_i;

    assign w_dz  = (bus.op2_i == '0);
    assign w_ovf = w_signed & (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op2_i == '1);

    always_comb begin
        w_special = '0;
        if (w_dz)
            w_special = w_is_div ? '1 : bus.op1_i;
        else if (w_is_div)
            w_special = {1'b1, {(XLEN-1){1'b0}}};
    end

    div_step u_step (
        .i_r (r_rem),
        .i_q (r_quo),
        .i_d (r_dvs),
        .o_r (w_rem_nxt),
        .o_q (w_quo_nxt)
    );

    assign w_quo_fin  = r_neg_q ? neg2c(w_quo_nxt) : w_quo_nxt;
    assign w_rem_fin  = r_neg_r ? neg2c(w_rem_nxt[XLEN-1:0]) : w_rem_nxt[XLEN-1:0];
    assign w_calc_res = r_is_rem ? w_rem_fin : w_quo_fin;

    assign bus.stall_o = ~bus.flush_i & (((r_state == IDLE) & bus.start_i) | (r_state == CALC));
    assign bus.valid_o = r_valid;
    assign bus.res_o   = r_res;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dvs    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // Flush only redirects the FSM; the last result stays on res_o.
            if (bus.flush_i) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start_i) begin
                            r_is_rem <= bus.div_op_i[1];
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_dvs    <= w_abs2;
                            if (w_dz | w_ovf) begin
                                r_res   <= w_special;
                                r_valid <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_rem   <= '0;
                                r_quo   <= w_abs1;
                                r_cnt   <= 5'(DIV_STEPS - 1);
                                r_state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (r_cnt == '0) begin
                            r_res   <= w_calc_res;
                            r_valid <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_div_seq.sv
// Bench for ex_div_seq: cycle-level latency/result model checked every cycle, directed corners plus random ops.
module tb_ex_div_seq;
    import core_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ex_div_seq_if bus ();

    ex_div_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RISC-V M-extension divide semantics straight from the ISA rules.
    function automatic logic [31:0] ref_div(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            REMU: return (b == 0) ? a : a % b;
            DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    function automatic int ref_lat(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if ((op == DIV || op == REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Model: m_cyc counts cycles since acceptance; the result is due at cycle m_lat.
    logic        m_busy = 1'b0;
    int          m_cyc  = 0;
    int          m_lat  = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_res  = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_cyc  <= 0;
            m_res  <= '0;
        end else if (bus.flush_i) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cyc == m_lat) begin
                m_busy <= 1'b0;
            end else begin
                m_cyc <= m_cyc + 1;
                if (m_cyc + 1 == m_lat) m_res <= m_pend;
            end
        end else if (bus.start_i) begin
            m_busy <= 1'b1;
            m_cyc  <= 1;
            m_lat  <= ref_lat(bus.div_op_i, bus.op1_i, bus.op2_i);
            m_pend <= ref_div(bus.div_op_i, bus.op1_i, bus.op2_i);
            if (ref_lat(bus.div_op_i, bus.op1_i, bus.op2_i) == 1)
                m_res <= ref_div(bus.div_op_i, bus.op1_i, bus.op2_i);
        end
    end

    wire e_valid = m_busy && (m_cyc == m_lat);
    wire e_stall = reset_n && !bus.flush_i && (m_busy ? (m_cyc < m_lat) : bus.start_i);

    always @(negedge clk) begin
        chk("stall_o", 32'(bus.stall_o), 32'(e_stall));
        chk("valid_o", 32'(bus.valid_o), 32'(e_valid));
        chk("res_o", bus.res_o, m_res);
    end

    task automatic run(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] r);
        bus.div_op_i = op;
        bus.op1_i    = a;
        bus.op2_i    = b;
        bus.start_i  = 1'b1;
        repeat (hold) begin @(posedge clk); #1; end
        bus.start_i  = 1'b0;
        for (int k = 0; k < 40 && m_busy; k++) begin @(posedge clk); #1; end
        chk("done_timeout", 32'(m_busy), 32'd0);
        r = bus.res_o;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] held;
        logic [31:0] a, b;
        div_op_t     op;

        bus.start_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.div_op_i = DIVU;
        bus.op1_i    = '0;
        bus.op2_i    = '0;

        chk("model_divu", ref_div(DIVU, 32'd100, 32'd7), 32'd14);
        chk("model_remu", ref_div(REMU, 32'd100, 32'd7), 32'd2);
        chk("model_div_neg", ref_div(DIV, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
        chk("model_rem_neg", ref_div(REM, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
        chk("model_lat_ovf", 32'(ref_lat(DIV, 32'h80000000, 32'hFFFFFFFF)), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_res", bus.res_o, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run(DIVU, 32'd100, 32'd7, 1, r);               chk("divu_100_7", r, 32'd14);
        run(REMU, 32'd100, 32'd7, 1, r);               chk("remu_100_7", r, 32'd2);
        run(DIV, 32'hFFFFFFF9, 32'd2, 1, r);           chk("div_m7_2", r, 32'hFFFFFFFD);
        run(REM, 32'hFFFFFFF9, 32'd2, 1, r);           chk("rem_m7_2", r, 32'hFFFFFFFF);
        run(DIV, 32'd7, 32'hFFFFFFFE, 1, r);           chk("div_7_m2", r, 32'hFFFFFFFD);
        run(DIV, 32'h1234, 32'd0, 1, r);               chk("div_by0", r, 32'hFFFFFFFF);
        run(REMU, 32'h1234, 32'd0, 1, r);              chk("remu_by0", r, 32'h1234);
        run(DIV, 32'h80000000, 32'hFFFFFFFF, 1, r);    chk("div_ovf", r, 32'h80000000);
        run(REM, 32'h80000000, 32'hFFFFFFFF, 1, r);    chk("rem_ovf", r, 32'h0);
        run(DIVU, 32'h80000000, 32'hFFFFFFFF, 1, r);   chk("divu_big", r, 32'h0);

        // Flush in CALC cycle 10.
        held = bus.res_o;
        bus.div_op_i = DIVU;
        bus.op1_i    = 32'd1000;
        bus.op2_i    = 32'd3;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        bus.start_i  = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush_i  = 1'b1;
        #3;
        chk("flush_stall", 32'(bus.stall_o), 32'd0);
        @(posedge clk); #1;
        bus.flush_i  = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk("flush_res_held", bus.res_o, held);
        run(DIVU, 32'd9, 32'd3, 34, r);                chk("divu_9_3_hold", r, 32'd3);
        repeat (3) begin @(posedge clk); #1; end

        // Reset in CALC cycle 5.
        bus.div_op_i = DIVU;
        bus.op1_i    = 32'd50;
        bus.op2_i    = 32'd5;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        bus.start_i  = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("midrst_stall", 32'(bus.stall_o), 32'd0);
        chk("midrst_valid", 32'(bus.valid_o), 32'd0);
        chk("midrst_res", bus.res_o, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run(DIVU, 32'hFFFFFFFF, 32'd1, 1, r);          chk("divu_max_1", r, 32'hFFFFFFFF);

        for (int i = 0; i < 60; i++) begin
            op = div_op_t'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                2:       a = $urandom_range(0, 255);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = 32'h0 - $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run(op, a, b, 1, r);
            chk("rand_res", r, ref_div(op, a, b));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Iterative divide sequencer for the RV32IM_Zbb execute stage. It takes DIV/DIVU/REM/REMU operands after operand forwarding, runs a 32-step restoring division, and holds the pipeline with a stall while it works. It resolves the RISC-V divide-by-zero and signed-overflow cases in one cycle. It sits beside the single-cycle ALU in `execute_phase`, and its result is muxed onto the EX result path when `valid_o` is high.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk`, in, 1: rising-edge clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: a divide instruction is present in EX. Sampled only in IDLE.
- `div_op_i`, in, 2: operation select. 00 DIV, 01 DIVU, 10 REM, 11 REMU. Sampled with `start_i`.
- `op1_i`, in, 32: dividend, taken after forwarding.
- `op2_i`, in, 32: divisor, taken after forwarding.
- `flush_i`, in, 1: pipeline flush. Aborts any operation in progress.
- `stall_o`, out, 1: freezes IF/ID/EX while asserted.
- `valid_o`, out, 1: `res_o` is valid. One-cycle pulse.
- `res_o`, out, 32: quotient or remainder. Holds its value until the next `valid_o`.

## Operation
- States are IDLE, CALC and DONE. The state encoding lives in the shared package.
- IDLE, with `start_i`=1 and `flush_i`=0:
  - Latch the op, the sign flags, |op1| and |op2|. Absolute values are taken only for DIV and REM.
  - Divisor zero, or signed overflow (DIV/REM with op1=0x80000000 and op2=0xFFFFFFFF): load the special result and go to DONE.
  - Otherwise: clear the 33-bit partial remainder R, load Q with |op1|, set the step counter to 31, and go to CALC.
- CALC, one step per cycle:
  - T = {R[31:0], Q[31]} − {0, divisor}.
  - If T[32]=0: R←T and Q←{Q[30:0],1}. Otherwise: R←{R[31:0],Q[31]} and Q←{Q[30:0],0}.
  - Leave for DONE when the counter reaches 0. That is exactly 32 steps.
- Entering DONE, the result is registered into `res_o`:
  - Quotient = Q, negated when the op is signed and the input signs differ.
  - Remainder = R[31:0], negated when the op is signed and op1 was negative.
  - `valid_o`=1 for that one cycle, then the block returns to IDLE.
- Special results:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- `start_i` is ignored in CALC and DONE. The same instruction is still in EX during DONE, so no re-trigger may occur.
- `flush_i`=1 in any state: next state is IDLE, no `valid_o` is produced, and `res_o` is unchanged. When flush and start occur in the same cycle, flush wins.
- `reset_n`=0 at any time, including mid-CALC, immediately forces IDLE, `stall_o`=0, `valid_o`=0, `res_o`=0 and the counter to 0.

## Timing
- `stall_o` is combinational: (IDLE & `start_i` & ~`flush_i`) | (CALC & ~`flush_i`). It is 0 in DONE, so the pipeline advances and captures `res_o` on that edge.
- Normal latency:
  - Start is accepted at cycle 0.
  - CALC occupies cycles 1–32.
  - `valid_o`=1 and `stall_o`=0 in cycle 33.
  - Total stall is 33 cycles.
- Special-case latency: start at cycle 0 (`stall_o`=1), then DONE at cycle 1.
- Back-to-back divides: the earliest next start is sampled in the cycle after DONE, when the block is back in IDLE.
- Reset values: `stall_o`=0, `valid_o`=0, `res_o`=0, state IDLE.
- Width rules:
  - R is 33 bits and the subtraction is 33 bits.
  - Negation is two's complement modulo 2^32, so |0x80000000| = 0x80000000 is handled correctly in unsigned form.

## Structure
- The shared package `core_pkg` holds:
  - `div_op_t` with values DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11.
  - `div_state_t` with values IDLE, CALC, DONE.
  - The constants `DIV_STEPS`=32 and `XLEN`.
- The one natural sub-module is `div_step`: the combinational single-iteration restoring step, with inputs R, Q and divisor and outputs R' and Q'.
- The FSM, counter, sign handling and special-case logic stay in `ex_div_seq`.

## Test plan
- **DIVU 100/7:** start at cycle 0. Expect `stall_o`=1 for cycles 0–32, `valid_o` at cycle 33 with `res_o`=14. The same operands with REMU give 2.
- **Signed DIV/REM with −7/2 (0xFFFFFFF9 / 2):** DIV gives 0xFFFFFFFD (−3). REM gives 0xFFFFFFFF (−1). DIV 7/−2 gives 0xFFFFFFFD.
- **Divide by zero, 0x1234/0:** DIV gives 0xFFFFFFFF and REMU gives 0x1234. Both have `valid_o` at cycle 1 and `stall_o` only in cycle 0.
- **Overflow, 0x80000000 / 0xFFFFFFFF:** DIV gives 0x80000000 and REM gives 0, each with `valid_o` at cycle 1. DIVU with the same operands runs the full 33 cycles and gives 0.
- **Flush and ignored start:** assert `flush_i` in CALC cycle 10. Expect `stall_o`=0 that cycle, no `valid_o`, and `res_o` unchanged. A new DIVU 9/3 then gives 3 after 33 cycles. Holding `start_i` high through DONE must not re-trigger.
- **Reset mid-operation:** pull `reset_n` low in CALC cycle 5. All outputs go to 0 immediately. After release, DIVU 0xFFFFFFFF/1 gives 0xFFFFFFFF.
